sprite_reader: RTL and testbench
================================

SPRITE_READER -- requirements
Module: sprite_reader

Interface
REQ-001 clk  input  1  system clock; all state on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 pixel_tick  input  1  one-cycle pulse per pixel; pixel_x, pixel_y, video_on, hsync_in, vsync_in and bg_rgb are sampled only when it is high.
REQ-004 pixel_x  input  10  current pixel column, 0..639 visible.
REQ-005 pixel_y  input  10  current pixel row, 0..479 visible.
REQ-006 video_on  input  1  visible-area flag.
REQ-007 hsync_in, vsync_in  input  1 each  raw sync signals.
REQ-008 frame_tick  input  1  one-cycle pulse at start of each frame.
REQ-009 show  input  1  level request to display the 32x64 game-over overlay.
REQ-010 bg_rgb  input  12  game-scene pixel colour.
REQ-011 rom_row  output  5  sprite ROM row address.
REQ-012 rom_col  output  6  sprite ROM column address.
REQ-013 rom_data  input  12  sprite ROM colour; valid one clk after rom_row/rom_col change (ROM registers address).
REQ-014 rgb_out  output  12  composited pixel.
REQ-015 hsync_out, vsync_out  output  1 each  syncs delayed to align with rgb_out.
REQ-016 overlay_active  output  1  high while state is BLINK or STEADY.

Function
REQ-017 rom_col SHALL equal floor(pixel_x/10) and rom_row floor(pixel_y/15), generated by sub-cell counters (no dividers), updated on the clk edge where pixel_tick is high.
REQ-018 Counters SHALL clear when pixel_x==0 (column) and pixel_y==0 (row); the row counter SHALL advance only when pixel_x==0.
REQ-019 Outside visible area (pixel_x>=640 or pixel_y>=480) rom_row/rom_col SHALL hold 0.
REQ-020 Stage 1: on pixel_tick, register address, video_on, syncs, bg_rgb; stage 2: one clk later, register rgb_out and syncs from rom_data; total latency 2 clk from the pixel_tick edge.
REQ-021 hsync_out/vsync_out SHALL carry exactly the same 2-clk delay as rgb_out.
REQ-022 States: OFF, BLINK, STEADY; encoding free.
REQ-023 OFF->BLINK: show high at a frame_tick; frame counter and toggle counter clear.
REQ-024 BLINK: 5-bit frame counter increments per frame_tick; at wrap 31->0 the blink phase toggles and the toggle counter increments; after 8 toggles -> STEADY at that frame_tick.
REQ-025 Any state -> OFF when show low at a frame_tick; show changes between frame_ticks SHALL have no effect (no mid-frame tearing).
REQ-026 Overlay visible when state==STEADY, or state==BLINK with phase==1; phase SHALL be 1 on entry to BLINK.
REQ-027 rgb_out SHALL be 0 when delayed video_on is low; bg_rgb when overlay not visible; otherwise rom_data per REQ-032.
REQ-028 Simultaneous frame_tick and pixel_tick SHALL both be honoured in the same cycle.

Reset
REQ-029 reset SHALL force state OFF, all counters 0, phase 0, pipeline registers 0.
REQ-030 After reset: rgb_out=0, hsync_out=0, vsync_out=0, rom_row=0, rom_col=0, overlay_active=0.
REQ-031 reset mid-frame SHALL take effect on the next edge; the overlay SHALL not reappear before the next frame_tick with show high.

Configuration
REQ-032 SPRITE_TRANSPARENT_EN defined: visible-overlay pixels with rom_data==12'h000 SHALL output bg_rgb; undefined: rom_data SHALL be output unconditionally (black box behind text).

Verification
REQ-033 pixel_x=25, pixel_y=130 on pixel_tick -> rom_col=2, rom_row=8 on the next edge; rgb_out updates 2 clk after the tick.
REQ-034 show=1, frame_tick -> overlay_active=1; phase toggles every 32 frames; STEADY after 256 frames.
REQ-035 show dropped mid-frame -> overlay persists to the frame's end; OFF at the next frame_tick.
REQ-036 rom_data=12'h000, bg_rgb=12'h0F0, overlay visible -> rgb_out=12'h0F0 with the macro, 12'h000 without.
REQ-037 video_on=0 with overlay visible -> rgb_out=0; hsync pulse -> hsync_out identical shape, 2 clk later.
REQ-038 reset asserted during BLINK -> next-cycle outputs all 0, state OFF.

Source files
------------

// File: rtl/sprite_reader_if.sv
// Pixel-stream, ROM and control bundle between the video timing source and sprite_reader.
interface sprite_reader_if;
    logic        pixel_tick;
    logic [9:0]  pixel_x;
    logic [9:0]  pixel_y;
    logic        video_on;
    logic        hsync_in;
    logic        vsync_in;
    logic        frame_tick;
    logic        show;
    logic [11:0] bg_rgb;
    logic [4:0]  rom_row;
    logic [5:0]  rom_col;
    logic [11:0] rom_data;
    logic [11:0] rgb_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        overlay_active;

    modport master (
        output pixel_tick, pixel_x, pixel_y, video_on, hsync_in, vsync_in,
               frame_tick, show, bg_rgb, rom_data,
        input  rom_row, rom_col, rgb_out, hsync_out, vsync_out, overlay_active
    );

    modport slave (
        input  pixel_tick, pixel_x, pixel_y, video_on, hsync_in, vsync_in,
               frame_tick, show, bg_rgb, rom_data,
        output rom_row, rom_col, rgb_out, hsync_out, vsync_out, overlay_active
    );
endinterface

// File: rtl/sprite_reader.sv
// Game-over overlay compositor: divider-free ROM addressing, 2-clk pixel pipeline, blink FSM.
// Build option SPRITE_TRANSPARENT_EN: ROM colour 12'h000 lets the background show through.
module sprite_reader (
    input  logic           clk,
    input  logic           reset,
    sprite_reader_if.slave bus
);
    typedef enum logic [1:0] {OFF, BLINK, STEADY} state_e;

    state_e      state_q, state_d;
    logic [4:0]  frame_q, frame_d;
    logic [3:0]  tog_q, tog_d;
    logic        phase_q, phase_d;

    logic [3:0]  csub_q, csub_d, rsub_q, rsub_d;
    logic [5:0]  ccnt_q, ccnt_d, rom_col_q;
    logic [4:0]  rcnt_q, rcnt_d, rom_row_q;
    logic        in_vis;

    logic        von1_q, hs1_q, vs1_q, von2_q, hs2_q, vs2_q, hso_q, vso_q;
    logic [11:0] bg1_q, bg2_q, rgb_q, rgb_d;
    logic        ovl_vis;

    // Overlay state only moves on frame_tick so a show change never tears a frame.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        tog_d   = tog_q;
        phase_d = phase_q;
        if (bus.frame_tick) begin
            if (!bus.show) begin
                state_d = OFF;
                frame_d = '0;
                tog_d   = '0;
                phase_d = 1'b0;
            end else begin
                case (state_q)
                    OFF: begin
                        state_d = BLINK;
                        frame_d = '0;
                        tog_d   = '0;
                        phase_d = 1'b1;
                    end
                    BLINK: begin
                        frame_d = frame_q + 5'd1;
                        if (frame_q == 5'd31) begin
                            phase_d = ~phase_q;
                            tog_d   = tog_q + 4'd1;
                            if (tog_q == 4'd7) state_d = STEADY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Sub-cell counters: 10 pixels per column, 15 lines per row.
    always_comb begin
        csub_d = csub_q;
        ccnt_d = ccnt_q;
        rsub_d = rsub_q;
        rcnt_d = rcnt_q;
        if (bus.pixel_x == 10'd0) begin
            csub_d = '0;
            ccnt_d = '0;
            if (bus.pixel_y == 10'd0) begin
                rsub_d = '0;
                rcnt_d = '0;
            end else if (rsub_q == 4'd14) begin
                rsub_d = '0;
                rcnt_d = rcnt_q + 5'd1;
            end else begin
                rsub_d = rsub_q + 4'd1;
            end
        end else if (csub_q == 4'd9) begin
            csub_d = '0;
            ccnt_d = ccnt_q + 6'd1;
        end else begin
            csub_d = csub_q + 4'd1;
        end
    end

    assign in_vis  = (bus.pixel_x < 10'd640) && (bus.pixel_y < 10'd480);
    assign ovl_vis = (state_q == STEADY) || ((state_q == BLINK) && phase_q);

    always_comb begin
        rgb_d = bus.rom_data;
        if (!von2_q) begin
            rgb_d = '0;
        end else if (!ovl_vis) begin
            rgb_d = bg2_q;
        end else begin
`ifdef SPRITE_TRANSPARENT_EN
            if (bus.rom_data == 12'h000) rgb_d = bg2_q;
`endif
        end
    end

    // The ROM registers the address, so sidebands wait one extra clk to meet rom_data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OFF;
            frame_q <= '0;
            tog_q   <= '0;
            phase_q <= 1'b0;
            csub_q  <= '0;
            ccnt_q  <= '0;
            rsub_q  <= '0;
            rcnt_q  <= '0;
            rom_col_q <= '0;
            rom_row_q <= '0;
            von1_q  <= 1'b0;
            hs1_q   <= 1'b0;
            vs1_q   <= 1'b0;
            bg1_q   <= '0;
            von2_q  <= 1'b0;
            hs2_q   <= 1'b0;
            vs2_q   <= 1'b0;
            bg2_q   <= '0;
            rgb_q   <= '0;
            hso_q   <= 1'b0;
            vso_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            tog_q   <= tog_d;
            phase_q <= phase_d;
            if (bus.pixel_tick) begin
                csub_q    <= csub_d;
                ccnt_q    <= ccnt_d;
                rsub_q    <= rsub_d;
                rcnt_q    <= rcnt_d;
                rom_col_q <= in_vis ? ccnt_d : 6'd0;
                rom_row_q <= in_vis ? rcnt_d : 5'd0;
                von1_q    <= bus.video_on;
                hs1_q     <= bus.hsync_in;
                vs1_q     <= bus.vsync_in;
                bg1_q     <= bus.bg_rgb;
            end
            von2_q <= von1_q;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            bg2_q  <= bg1_q;
            rgb_q  <= rgb_d;
            hso_q  <= hs2_q;
            vso_q  <= vs2_q;
        end
    end

    assign bus.rom_col        = rom_col_q;
    assign bus.rom_row        = rom_row_q;
    assign bus.rgb_out        = rgb_q;
    assign bus.hsync_out      = hso_q;
    assign bus.vsync_out      = vso_q;
    assign bus.overlay_active = (state_q != OFF);
endmodule

// File: tb/tb_sprite_reader.sv
// Directed bench for sprite_reader: vector table for compositing plus blink/reset sequences.
module tb_sprite_reader;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sprite_reader_if bus();

    sprite_reader dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Synchronous ROM model: registers the address, data one clk later.
    function automatic logic [11:0] rom_f(input logic [4:0] r, input logic [5:0] c);
        logic [3:0] rr;
        if (r == 5'd0 && c == 6'd0) return 12'h000;
        rr = r[3:0] + 4'h1;
        return {rr, c[3:0], 4'h5};
    endfunction
    always_ff @(posedge clk) bus.rom_data <= rom_f(bus.rom_row, bus.rom_col);

`ifdef SPRITE_TRANSPARENT_EN
    localparam logic [11:0] TRANSP_EXP = 12'h0F0;
`else
    localparam logic [11:0] TRANSP_EXP = 12'h000;
`endif

    typedef struct {
        logic        ovl;
        int          x;
        logic        von;
        logic [11:0] bg;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic cur_ovl;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int k);
        for (int i = 0; i < k; i++) begin
            bus.frame_tick = 1'b1;
            tick_edge();
            bus.frame_tick = 1'b0;
        end
    endtask

    // Scan pixels 0..x on line 0, then wait until the last one reaches rgb_out.
    task automatic run_pixel(input int x, input logic von, input logic [11:0] bg,
                             input logic hs, input logic vs);
        for (int i = 0; i <= x; i++) begin
            bus.pixel_x    = 10'(i);
            bus.pixel_y    = 10'd0;
            bus.video_on   = von;
            bus.bg_rgb     = bg;
            bus.hsync_in   = hs;
            bus.vsync_in   = vs;
            bus.pixel_tick = 1'b1;
            tick_edge();
        end
        bus.pixel_tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic probe(input string nm, input logic exp_vis);
        run_pixel(12, 1'b1, 12'hABC, 1'b0, 1'b0);
        chk(nm, bus.rgb_out, exp_vis ? 32'h115 : 32'hABC);
    endtask

    vec_t vecs[7];
    logic [7:0] hpat;
    logic [9:0] hist_h, hist_v;
    int n;

    initial begin
        vecs[0] = '{1'b0, 12, 1'b1, 12'hABC, 1'b0, 1'b0, 12'hABC};
        vecs[1] = '{1'b0, 25, 1'b0, 12'h123, 1'b1, 1'b0, 12'h000};
        vecs[2] = '{1'b0,  0, 1'b1, 12'h0F0, 1'b0, 1'b1, 12'h0F0};
        vecs[3] = '{1'b1, 12, 1'b1, 12'hABC, 1'b0, 1'b0, 12'h115};
        vecs[4] = '{1'b1, 25, 1'b1, 12'h777, 1'b1, 1'b1, 12'h125};
        vecs[5] = '{1'b1, 25, 1'b0, 12'h777, 1'b0, 1'b0, 12'h000};
        vecs[6] = '{1'b1,  9, 1'b1, 12'h0F0, 1'b0, 1'b0, TRANSP_EXP};

        // Reset held with every input active: all outputs must read 0.
        reset = 1'b1;
        bus.pixel_tick = 1'b1; bus.pixel_x = 10'd37; bus.pixel_y = 10'd40;
        bus.video_on = 1'b1; bus.hsync_in = 1'b1; bus.vsync_in = 1'b1;
        bus.frame_tick = 1'b1; bus.show = 1'b1; bus.bg_rgb = 12'hFFF;
        repeat (3) tick_edge();
        chk("reset_rgb", bus.rgb_out, 0);
        chk("reset_hs", bus.hsync_out, 0);
        chk("reset_vs", bus.vsync_out, 0);
        chk("reset_row", bus.rom_row, 0);
        chk("reset_col", bus.rom_col, 0);
        chk("reset_ovl", bus.overlay_active, 0);
        reset = 1'b0;
        bus.pixel_tick = 1'b0; bus.frame_tick = 1'b0; bus.show = 1'b0;
        bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.video_on = 1'b0;
        bus.pixel_x = 10'd0; bus.pixel_y = 10'd0; bus.bg_rgb = 12'h000;
        tick_edge();

        // Address generation: line starts down to y=130, then across to x=25.
        bus.pixel_tick = 1'b1;
        for (int y = 0; y <= 130; y++) begin
            bus.pixel_x = 10'd0;
            bus.pixel_y = 10'(y);
            tick_edge();
            if (y == 14) chk("row_y14", bus.rom_row, 0);
            if (y == 15) chk("row_y15", bus.rom_row, 1);
        end
        for (int x = 1; x <= 25; x++) begin
            bus.pixel_x = 10'(x);
            tick_edge();
            if (x == 9)  chk("col_x9", bus.rom_col, 0);
            if (x == 10) chk("col_x10", bus.rom_col, 1);
        end
        chk("addr_col_25", bus.rom_col, 25 / 10);
        chk("addr_row_130", bus.rom_row, 130 / 15);
        bus.pixel_x = 10'd700;
        tick_edge();
        chk("blank_x_col", bus.rom_col, 0);
        chk("blank_x_row", bus.rom_row, 0);
        bus.pixel_x = 10'd0;
        bus.pixel_y = 10'd500;
        tick_edge();
        chk("blank_y_row", bus.rom_row, 0);

        // Sync shape: pixel_tick every clk, syncs must come out exactly 2 clk later.
        hpat = 8'b0001_0110;
        hist_h = '0;
        hist_v = '0;
        bus.pixel_y = 10'd0;
        for (int i = 0; i < 8; i++) begin
            bus.hsync_in = hpat[i];
            bus.vsync_in = ~hpat[i];
            tick_edge();
            hist_h = {hist_h[8:0], hpat[i]};
            hist_v = {hist_v[8:0], ~hpat[i]};
            if (i >= 2) begin
                chk($sformatf("hs_shape_%0d", i), bus.hsync_out, hist_h[2]);
                chk($sformatf("vs_shape_%0d", i), bus.vsync_out, hist_v[2]);
            end
        end
        bus.pixel_tick = 1'b0;
        bus.hsync_in = 1'b1;
        repeat (3) tick_edge();
        chk("hs_hold_no_tick", bus.hsync_out, hpat[7]);
        bus.hsync_in = 1'b0;
        bus.vsync_in = 1'b0;

        // Compositing vectors.
        cur_ovl = 1'b0;
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].ovl != cur_ovl) begin
                bus.show = vecs[v].ovl;
                frames(1);
                cur_ovl = vecs[v].ovl;
            end
            run_pixel(vecs[v].x, vecs[v].von, vecs[v].bg, vecs[v].hs, vecs[v].vs);
            chk($sformatf("vec%0d_rgb", v), bus.rgb_out, vecs[v].rgb);
            chk($sformatf("vec%0d_hs", v), bus.hsync_out, vecs[v].hs);
            chk($sformatf("vec%0d_vs", v), bus.vsync_out, vecs[v].vs);
            chk($sformatf("vec%0d_ovl", v), bus.overlay_active, vecs[v].ovl);
        end

        // Blink timing from a clean OFF.
        bus.show = 1'b0;
        frames(1);
        chk("blink_off", bus.overlay_active, 0);
        bus.show = 1'b1;
        frames(1);
        n = 0;
        chk("blink_enter_ovl", bus.overlay_active, 1);
        probe("blink_n0", 1'b1);
        foreach (hist_h[i]) ; // no-op guard against empty loops in some tools
        for (int t = 0; t < 8; t++) begin
            int tgt;
            case (t)
                0: tgt = 31;  1: tgt = 32;  2: tgt = 63;  3: tgt = 64;
                4: tgt = 255; 5: tgt = 256; 6: tgt = 290; default: tgt = 300;
            endcase
            frames(tgt - n);
            n = tgt;
            probe($sformatf("blink_n%0d", n), (n >= 256) ? 1'b1 : (((n / 32) % 2) == 0));
            chk($sformatf("blink_ovl_n%0d", n), bus.overlay_active, 1);
        end

        // Show dropped mid-frame: overlay holds until the next frame_tick.
        bus.show = 1'b0;
        repeat (5) tick_edge();
        chk("drop_mid_ovl", bus.overlay_active, 1);
        probe("drop_mid_vis", 1'b1);
        frames(1);
        chk("drop_frame_ovl", bus.overlay_active, 0);
        probe("drop_frame_vis", 1'b0);

        // Show raised mid-frame: no effect without frame_tick.
        bus.show = 1'b1;
        repeat (5) tick_edge();
        chk("raise_mid_ovl", bus.overlay_active, 0);

        // frame_tick and pixel_tick together.
        bus.frame_tick = 1'b1;
        bus.pixel_tick = 1'b1;
        bus.pixel_x = 10'd0; bus.pixel_y = 10'd0;
        bus.hsync_in = 1'b1; bus.video_on = 1'b1;
        tick_edge();
        bus.frame_tick = 1'b0;
        bus.pixel_tick = 1'b0;
        bus.hsync_in = 1'b0;
        chk("both_ovl", bus.overlay_active, 1);
        chk("both_col", bus.rom_col, 0);
        tick_edge();
        chk("both_hs_early", bus.hsync_out, 0);
        tick_edge();
        chk("both_hs_2clk", bus.hsync_out, 1);

        // Reset during BLINK.
        reset = 1'b1;
        bus.pixel_tick = 1'b1; bus.video_on = 1'b1; bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1; bus.bg_rgb = 12'hFFF;
        tick_edge();
        chk("rst_blink_rgb", bus.rgb_out, 0);
        chk("rst_blink_hs", bus.hsync_out, 0);
        chk("rst_blink_vs", bus.vsync_out, 0);
        chk("rst_blink_row", bus.rom_row, 0);
        chk("rst_blink_col", bus.rom_col, 0);
        chk("rst_blink_ovl", bus.overlay_active, 0);
        reset = 1'b0;
        bus.pixel_tick = 1'b0; bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
        probe("rst_no_reappear", 1'b0);
        chk("rst_no_reappear_ovl", bus.overlay_active, 0);
        frames(1);
        chk("rst_reenter_ovl", bus.overlay_active, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
